// File: rtl/a2d_pkg.sv
// a2d_pkg
//   Shared constants for the A2D SPI slave model: channel numbers, frame
//   length, bit-counter width and the channel-to-sample select function.
package a2d_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = 5;

  localparam logic [2:0] CH_BATT   = 3'd0;
  localparam logic [2:0] CH_CURR   = 3'd1;
  localparam logic [2:0] CH_BRAKE  = 3'd3;
  localparam logic [2:0] CH_TORQUE = 3'd4;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

  // Unpopulated channels (2, 5, 6, 7) read back as zero.
  function automatic logic [11:0] chan_value(
    input logic [2:0]  chan,
    input logic [11:0] batt,
    input logic [11:0] curr,
    input logic [11:0] brake,
    input logic [11:0] torque
  );
    logic [11:0] val;
    val = 12'h000;
    case (chan)
      CH_BATT:   val = batt;
      CH_CURR:   val = curr;
      CH_BRAKE:  val = brake;
      CH_TORQUE: val = torque;
      default:   val = 12'h000;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge
//   Two-flop synchronizer for an asynchronous pin plus a history flop used
//   to produce single-cycle edge strobes.
//   Ports:
//     clk     system clock
//     rst_n   synchronous active-low reset (all flops load RST_VAL)
//     d_in    asynchronous input pin
//     q       synchronized level
//     rise    one-clk strobe on a synchronized 0->1 transition
//     fall    one-clk strobe on a synchronized 1->0 transition
module sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic q,
  output logic rise,
  output logic fall
);

  logic ff1_q, ff1_d;
  logic ff2_q, ff2_d;
  logic hist_q, hist_d;

  always_comb begin
    ff1_d  = d_in;
    ff2_d  = ff1_q;
    hist_d = ff2_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff1_q  <= RST_VAL;
      ff2_q  <= RST_VAL;
      hist_q <= RST_VAL;
    end else begin
      ff1_q  <= ff1_d;
      ff2_q  <= ff2_d;
      hist_q <= hist_d;
    end
  end

  assign q    = ff2_q;
  assign rise = ff2_q & ~hist_q;
  assign fall = ~ff2_q & hist_q;

endmodule

// File: rtl/analog_model.sv
// analog_model
//   Synthesizable model of an 8-channel 12-bit SPI A2D converter. Each
//   16-bit frame returns the sample of the channel commanded by the
//   previous complete frame (command in MOSI bits [13:11]).
//   Ports:
//     clk, rst_n             system clock, synchronous active-low reset
//     SS_n, SCLK, MOSI       SPI inputs, asynchronous to clk
//     MISO                   SPI data out (0 while deselected)
//     BATT, CURR, BRAKE,     analog samples for channels 0, 1, 3, 4
//     TORQUE
module analog_model
  import a2d_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] BATT,
  input  logic [11:0] CURR,
  input  logic [11:0] BRAKE,
  input  logic [11:0] TORQUE
);

  logic ss_sync, ss_fall, ss_rise;
  logic sclk_rise;
  logic sclk_lvl_unused, sclk_fall_unused;

  sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_in (SS_n),
    .q    (ss_sync),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_in (SCLK),
    .q    (sclk_lvl_unused),
    .rise (sclk_rise),
    .fall (sclk_fall_unused)
  );

  // MOSI uses only the two-flop path so it lines up with the synchronized
  // SCLK level: at the sclk_rise strobe it holds the bit valid at the pin
  // rise.
  logic mosi_ff1_q, mosi_ff1_d;
  logic mosi_ff2_q, mosi_ff2_d;

  logic [15:0]      shft_q, shft_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             over_q, over_d;
  logic [2:0]       chan_q, chan_d;

  always_comb begin
    mosi_ff1_d = MOSI;
    mosi_ff2_d = mosi_ff1_q;

    shft_d = shft_q;
    cnt_d  = cnt_q;
    over_d = over_q;
    chan_d = chan_q;

    if (ss_fall) begin
      // Sample the analog input once, at frame start.
      shft_d = {4'h0, chan_value(chan_q, BATT, CURR, BRAKE, TORQUE)};
      cnt_d  = '0;
      over_d = 1'b0;
    end else if (sclk_rise && !ss_sync) begin
      shft_d = {shft_q[14:0], mosi_ff2_q};
      if (cnt_q == CNT_FULL) begin
        // Counter holds at 16; remember the overrun so the frame is
        // treated as aborted at ss_rise.
        over_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (ss_rise && (cnt_q == CNT_FULL) && !over_q) begin
      chan_d = shft_q[13:11];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mosi_ff1_q <= 1'b0;
      mosi_ff2_q <= 1'b0;
      shft_q     <= 16'h0000;
      cnt_q      <= '0;
      over_q     <= 1'b0;
      chan_q     <= CH_BATT;
    end else begin
      mosi_ff1_q <= mosi_ff1_d;
      mosi_ff2_q <= mosi_ff2_d;
      shft_q     <= shft_d;
      cnt_q      <= cnt_d;
      over_q     <= over_d;
      chan_q     <= chan_d;
    end
  end

  assign MISO = ~ss_sync & shft_q[15];

endmodule

// File: tb/tb_analog_model.sv
module tb_analog_model;

  logic        clk;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [11:0] BATT;
  logic [11:0] CURR;
  logic [11:0] BRAKE;
  logic [11:0] TORQUE;

  int n_tests;
  int n_fail;

  analog_model dut (
    .clk   (clk),
    .rst_n (rst_n),
    .SS_n  (SS_n),
    .SCLK  (SCLK),
    .MOSI  (MOSI),
    .MISO  (MISO),
    .BATT  (BATT),
    .CURR  (CURR),
    .BRAKE (BRAKE),
    .TORQUE(TORQUE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 16'h%04h expected 16'h%04h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cmd_word(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

  task automatic spi_start();
    @(negedge clk);
    SS_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Controller samples MISO at its own SCLK rise, before the slave shifts.
  task automatic spi_bit(input logic b, output logic m);
    SCLK = 1'b0;
    MOSI = b;
    repeat (6) @(negedge clk);
    m = MISO;
    SCLK = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_end();
    repeat (2) @(negedge clk);
    SS_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_frame(input logic [15:0] word, input int nbits, output logic [15:0] rd);
    logic b;
    logic m;
    rd = 16'h0000;
    spi_start();
    for (int i = 0; i < nbits; i++) begin
      b = (i < 16) ? word[15 - i] : 1'b0;
      spi_bit(b, m);
      if (i < 16) rd[15 - i] = m;
    end
    spi_end();
  endtask

  logic [15:0] rd;
  logic        m;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    SS_n    = 1'b1;
    SCLK    = 1'b1;
    MOSI    = 1'b0;
    BATT    = 12'hB80;
    CURR    = 12'h123;
    BRAKE   = 12'h0FF;
    TORQUE  = 12'h700;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    chk("reset_miso", {15'h0, MISO}, 16'h0000);

    spi_frame(cmd_word(3'd0), 16, rd); chk("f1_batt", rd, 16'h0B80);
    spi_frame(cmd_word(3'd4), 16, rd); chk("f2_batt_again", rd, 16'h0B80);
    spi_frame(cmd_word(3'd3), 16, rd); chk("f3_torque", rd, 16'h0700);
    spi_frame(cmd_word(3'd1), 16, rd); chk("f4_brake", rd, 16'h00FF);
    spi_frame(cmd_word(3'd6), 16, rd); chk("f5_curr", rd, 16'h0123);
    spi_frame(cmd_word(3'd3), 16, rd); chk("f6_chan6_zero", rd, 16'h0000);

    // Aborted ch4 command after 8 bits: only the top byte of BRAKE returns.
    spi_frame(cmd_word(3'd4), 8, rd);  chk("f7_abort_partial", rd, 16'h0000);
    spi_frame(cmd_word(3'd4), 16, rd); chk("f8_after_abort_brake", rd, 16'h00FF);

    // 17 SCLK rises with a ch1 command: the frame must be ignored.
    spi_frame(cmd_word(3'd1), 17, rd); chk("f9_overrun_torque", rd, 16'h0700);
    spi_frame(cmd_word(3'd4), 16, rd); chk("f10_after_overrun", rd, 16'h0700);

    // TORQUE changes mid-frame; the sample is taken at frame start.
    rd = 16'h0000;
    spi_start();
    for (int i = 0; i < 16; i++) begin
      if (i == 6) TORQUE = 12'h7FF;
      spi_bit(cmd_word(3'd4) >> (15 - i) & 16'h1, m);
      rd[15 - i] = m;
    end
    spi_end();
    chk("f11_midframe_old", rd, 16'h0700);
    spi_frame(cmd_word(3'd4), 16, rd); chk("f12_new_torque", rd, 16'h07FF);

    // Reset mid-frame: after 5 shifts MISO shows bit 10 of 0x07FF.
    spi_start();
    for (int i = 0; i < 5; i++) spi_bit(1'b0, m);
    chk("pre_reset_miso", {15'h0, MISO}, 16'h0001);
    rst_n = 1'b0;
    SS_n  = 1'b1;
    SCLK  = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_midframe_miso", {15'h0, MISO}, 16'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    spi_frame(cmd_word(3'd0), 16, rd); chk("post_reset_batt", rd, 16'h0B80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
